// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the configurable UART core:
//                parity mode enum, TX/RX state enums, frame length and
//                word parity functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Widest data word the core supports; parity helper is sized to this.
   localparam int MAX_DATA_W = 9;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_e;

   // Total bits on the line for one frame: start + data + optional parity + stops.
   function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
      return 1 + data_w + ((parity != 0) ? 1 : 0) + stop_bits;
   endfunction

   // XOR of all bits of a (zero-extended) word; 1 means an odd number of ones.
   function automatic logic word_parity(input logic [MAX_DATA_W-1:0] word);
      return ^word;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Free-running mod-BAUD_DIV counter producing a one-cycle
//                oversample tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = 27
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int               CNT_W    = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Wrap the divider on its last count; the tick marks that cycle.
   always_comb begin
      tick  = (cnt_q == CNT_LAST);
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
   end

   // Divider register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule
`default_nettype wire

// File: rtl/uart_cfg_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cfg_core
//  Description : Configurable UART transceiver (5-9 data bits, none/odd/even
//                parity, 1-2 stop bits) with 16x-style oversampled receiver,
//                false-start rejection, error flags and internal loopback.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cfg_core
   import uart_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int OVS       = 16,
   parameter int BAUD_DIV  = 27
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              wr_en,
   output logic              busy,
   output logic              tx,
   input  logic              rx,
   input  logic              loopback,
   output logic [DATA_W-1:0] data_out,
   output logic              ready,
   input  logic              ready_clr,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overrun
);

   localparam int   BIT_CYC    = OVS * BAUD_DIV;
   localparam int   FRAME_BITS = frame_bits(DATA_W, PARITY, STOP_BITS);
   localparam logic HAS_PAR    = (PARITY != 0);
   localparam logic ODD_PAR    = (PARITY == int'(PAR_ODD));
   localparam int   BIT_W      = 4;
   localparam int   TXC_W      = $clog2(BIT_CYC);
   localparam int   RXC_W      = $clog2(OVS);

   // TX bit index runs over the whole frame: 0 = start, 1..DATA_W = data.
   localparam logic [TXC_W-1:0] TXC_LAST       = TXC_W'(BIT_CYC - 1);
   localparam logic [BIT_W-1:0] TX_LAST_DATA   = BIT_W'(DATA_W);
   localparam logic [BIT_W-1:0] TX_LAST_FRAME  = BIT_W'(FRAME_BITS - 1);
   // RX bit index restarts per field (data bits, then stop bits).
   localparam logic [RXC_W-1:0] RXC_HALF       = RXC_W'(OVS / 2 - 1);
   localparam logic [RXC_W-1:0] RXC_LAST       = RXC_W'(OVS - 1);
   localparam logic [BIT_W-1:0] RX_LAST_DATA   = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] RX_LAST_STOP   = BIT_W'(STOP_BITS - 1);

   logic tick;

   uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // ------------------------------------------------------------------------
   // Transmitter: bit timing counted in clk cycles from acceptance so the
   // frame length is exact regardless of the oversample tick phase.
   // ------------------------------------------------------------------------
   tx_state_e         tx_state_q, tx_state_d;
   logic [TXC_W-1:0]  tx_cnt_q,   tx_cnt_d;
   logic [BIT_W-1:0]  tx_bit_q,   tx_bit_d;
   logic [DATA_W-1:0] tx_sh_q,    tx_sh_d;
   logic              tx_par_q,   tx_par_d;
   logic              tx_q,       tx_d;
   logic              busy_q,     busy_d;

   // TX next state, shift register and registered line level.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_par_d   = tx_par_q;
      if (tx_state_q == TX_IDLE) begin
         tx_cnt_d = '0;
         tx_bit_d = '0;
         if (wr_en && !busy_q) begin
            tx_state_d = TX_START;
            tx_sh_d    = data_in;
            tx_par_d   = word_parity(MAX_DATA_W'(data_in)) ^ ODD_PAR;
         end
      end else if (tx_cnt_q != TXC_LAST) begin
         tx_cnt_d = tx_cnt_q + TXC_W'(1);
      end else begin
         tx_cnt_d = '0;
         tx_bit_d = tx_bit_q + BIT_W'(1);
         case (tx_state_q)
            TX_START:  tx_state_d = TX_DATA;
            TX_DATA: begin
               tx_sh_d = tx_sh_q >> 1;
               if (tx_bit_q == TX_LAST_DATA) tx_state_d = HAS_PAR ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: tx_state_d = TX_STOP;
            default:   if (tx_bit_q == TX_LAST_FRAME) tx_state_d = TX_IDLE;
         endcase
      end
      case (tx_state_d)
         TX_START:  tx_d = 1'b0;
         TX_DATA:   tx_d = tx_sh_d[0];
         TX_PARITY: tx_d = tx_par_d;
         default:   tx_d = 1'b1;
      endcase
      busy_d = (tx_state_d != TX_IDLE);
   end

   // TX registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_par_q   <= tx_par_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;

   // ------------------------------------------------------------------------
   // Receiver: synchronised pin, loopback mux after the synchroniser, FSM
   // stepping on oversample ticks and sampling at mid-bit.
   // ------------------------------------------------------------------------
   logic              rx_s1_q, rx_s2_q;
   logic              rx_line;
   rx_state_e         rx_state_q, rx_state_d;
   logic [RXC_W-1:0]  rx_cnt_q,   rx_cnt_d;
   logic [BIT_W-1:0]  rx_bit_q,   rx_bit_d;
   logic [DATA_W-1:0] rx_sh_q,    rx_sh_d;
   logic              rx_par_q,   rx_par_d;
   logic              rx_ferr_q,  rx_ferr_d;
   logic              rx_done;
   logic              rx_perr;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              ready_q,    ready_d;
   logic              perr_q,     perr_d;
   logic              ferr_q,     ferr_d;
   logic              ovr_q,      ovr_d;

   assign rx_line = loopback ? tx_q : rx_s2_q;
   assign rx_perr = HAS_PAR & (word_parity(MAX_DATA_W'(rx_sh_q)) ^ rx_par_q ^ ODD_PAR);

   // RX next state, sampling and delivery of completed frames to the host side.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_par_d   = rx_par_q;
      rx_ferr_d  = rx_ferr_q;
      rx_done    = 1'b0;
      data_out_d = data_out_q;
      ready_d    = ready_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      ovr_d      = ovr_q;
      if (tick) begin
         case (rx_state_q)
            RX_IDLE: begin
               if (!rx_line) begin
                  rx_state_d = RX_START;
                  rx_cnt_d   = '0;
               end
            end
            RX_START: begin
               if (rx_cnt_q == RXC_HALF) begin
                  rx_cnt_d   = '0;
                  rx_bit_d   = '0;
                  rx_ferr_d  = 1'b0;
                  // A high level at mid-start is a glitch, not a frame.
                  rx_state_d = rx_line ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_d = rx_cnt_q + RXC_W'(1);
               end
            end
            RX_DATA: begin
               if (rx_cnt_q == RXC_LAST) begin
                  rx_cnt_d = '0;
                  rx_sh_d  = {rx_line, rx_sh_q[DATA_W-1:1]};
                  if (rx_bit_q == RX_LAST_DATA) begin
                     rx_bit_d   = '0;
                     rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                  end else begin
                     rx_bit_d = rx_bit_q + BIT_W'(1);
                  end
               end else begin
                  rx_cnt_d = rx_cnt_q + RXC_W'(1);
               end
            end
            RX_PARITY: begin
               if (rx_cnt_q == RXC_LAST) begin
                  rx_cnt_d   = '0;
                  rx_par_d   = rx_line;
                  rx_state_d = RX_STOP;
               end else begin
                  rx_cnt_d = rx_cnt_q + RXC_W'(1);
               end
            end
            default: begin
               if (rx_cnt_q == RXC_LAST) begin
                  rx_cnt_d = '0;
                  if (!rx_line) rx_ferr_d = 1'b1;
                  if (rx_bit_q == RX_LAST_STOP) begin
                     rx_state_d = RX_IDLE;
                     rx_done    = 1'b1;
                  end else begin
                     rx_bit_d = rx_bit_q + BIT_W'(1);
                  end
               end else begin
                  rx_cnt_d = rx_cnt_q + RXC_W'(1);
               end
            end
         endcase
      end
      if (ready_clr) begin
         ready_d = 1'b0;
         perr_d  = 1'b0;
         ferr_d  = 1'b0;
         ovr_d   = 1'b0;
      end
      // Completion overrides a same-cycle clear; an unread word is kept.
      if (rx_done) begin
         if (ready_q && !ready_clr) begin
            ovr_d = 1'b1;
         end else begin
            data_out_d = rx_sh_q;
            perr_d     = rx_perr;
            ferr_d     = rx_ferr_d;
            ready_d    = 1'b1;
            ovr_d      = 1'b0;
         end
      end
   end

   // RX synchroniser, FSM and host-side output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_par_q   <= 1'b0;
         rx_ferr_q  <= 1'b0;
         data_out_q <= '0;
         ready_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         rx_s1_q    <= rx;
         rx_s2_q    <= rx_s1_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_par_q   <= rx_par_d;
         rx_ferr_q  <= rx_ferr_d;
         data_out_q <= data_out_d;
         ready_q    <= ready_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
      end
   end

   assign data_out   = data_out_q;
   assign ready      = ready_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cfg_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cfg_core
//  Description : Self-checking bench for uart_cfg_core: an 8N1 instance
//                (loopback, framing, overrun, false start, reset, busy) and
//                an 8E1 instance (parity), with a bit-level line model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_cfg_core;

   localparam int BD  = 4;
   localparam int OV  = 16;
   localparam int BIT = BD * OV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [7:0] data_in_a = 8'h00;
   logic       wr_en_a   = 1'b0;
   logic       busy_a, tx_a;
   logic       rx_a      = 1'b1;
   logic       loop_a    = 1'b0;
   logic [7:0] dout_a;
   logic       ready_a, perr_a, ferr_a, ovr_a;
   logic       clr_a     = 1'b0;

   logic [7:0] data_in_b = 8'h00;
   logic       wr_en_b   = 1'b0;
   logic       busy_b, tx_b;
   logic       rx_b      = 1'b1;
   logic       loop_b    = 1'b0;
   logic [7:0] dout_b;
   logic       ready_b, perr_b, ferr_b, ovr_b;
   logic       clr_b     = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;

   uart_cfg_core #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .OVS(OV), .BAUD_DIV(BD)) dut_a (
      .clk(clk), .rst(rst), .data_in(data_in_a), .wr_en(wr_en_a), .busy(busy_a), .tx(tx_a),
      .rx(rx_a), .loopback(loop_a), .data_out(dout_a), .ready(ready_a), .ready_clr(clr_a),
      .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a)
   );

   uart_cfg_core #(.DATA_W(8), .PARITY(2), .STOP_BITS(1), .OVS(OV), .BAUD_DIV(BD)) dut_b (
      .clk(clk), .rst(rst), .data_in(data_in_b), .wr_en(wr_en_b), .busy(busy_b), .tx(tx_b),
      .rx(rx_b), .loopback(loop_b), .data_out(dout_b), .ready(ready_b), .ready_clr(clr_b),
      .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle just after the last one.
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Even parity bit of a byte from its population count.
   function automatic logic even_bit(input logic [7:0] d);
      return ($countones(d) % 2) == 1;
   endfunction

   task automatic set_rx(input bit sel, input logic v);
      if (sel) rx_b = v;
      else     rx_a = v;
   endtask

   // Drive one frame on a pin: start, 8 data LSB first, optional parity, one stop.
   task automatic send_rx(input bit sel, input logic [7:0] d, input bit has_par,
                          input logic pbit, input logic stop_v);
      set_rx(sel, 1'b0);
      cycles(BIT);
      for (int i = 0; i < 8; i++) begin
         set_rx(sel, d[i]);
         cycles(BIT);
      end
      if (has_par) begin
         set_rx(sel, pbit);
         cycles(BIT);
      end
      set_rx(sel, stop_v);
      cycles(BIT);
      set_rx(sel, 1'b1);
      cycles(2 * BIT);
   endtask

   task automatic clear_a();
      clr_a = 1'b1;
      cycles(1);
      clr_a = 1'b0;
   endtask

   task automatic clear_b();
      clr_b = 1'b1;
      cycles(1);
      clr_b = 1'b0;
   endtask

   // Transmit on instance A and measure how long busy stays high.
   task automatic lb_send(input logic [7:0] d);
      int n;
      data_in_a = d;
      wr_en_a   = 1'b1;
      cycles(1);
      wr_en_a   = 1'b0;
      check("tx_busy_rise", busy_a, 1);
      check("tx_start_bit", tx_a, 0);
      n = 1;
      while (busy_a === 1'b1 && n < 2000) begin
         cycles(1);
         if (busy_a === 1'b1) n++;
      end
      check("busy_len", n, 10 * BIT);
   endtask

   initial begin
      logic [7:0] d;
      logic       p;
      logic [9:0] fr;
      int         extra;

      // Reset state
      cycles(4);
      rst = 1'b0;
      cycles(1);
      check("rst_tx",    tx_a,   1);
      check("rst_busy",  busy_a, 0);
      check("rst_ready", ready_a, 0);
      check("rst_dout",  dout_a, 0);
      check("rst_flags", {perr_a, ferr_a, ovr_a}, 0);
      check("rst_b_line", {tx_b, busy_b, ready_b}, 3'b100);

      // Loopback 8N1
      loop_a = 1'b1;
      lb_send(8'h25);
      cycles(2);
      check("lb25_ready", ready_a, 1);
      check("lb25_data",  dout_a, 8'h25);
      check("lb25_flags", {perr_a, ferr_a, ovr_a}, 0);
      clear_a();
      check("lb_clr_ready", ready_a, 0);
      lb_send(8'h77);
      cycles(2);
      check("lb77_data",  dout_a, 8'h77);
      check("lb77_flags", {ready_a, perr_a, ferr_a, ovr_a}, 4'b1000);
      clear_a();
      repeat (3) begin
         d = 8'($urandom);
         lb_send(d);
         cycles(2);
         check("lb_rand_data", dout_a, d);
         check("lb_rand_flags", {ready_a, perr_a, ferr_a, ovr_a}, 4'b1000);
         clear_a();
      end
      loop_a = 1'b0;

      // Even parity, wrong parity bit
      send_rx(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
      check("par_ready", ready_b, 1);
      check("par_data",  dout_b, 8'hA5);
      check("par_err",   perr_b, 1);
      check("par_ferr",  ferr_b, 0);
      clear_b();
      repeat (4) begin
         d = 8'($urandom);
         p = ($urandom % 2 == 0) ? even_bit(d) : ~even_bit(d);
         send_rx(1'b1, d, 1'b1, p, 1'b1);
         check("par_rand_data", dout_b, d);
         check("par_rand_err",  perr_b, (p != even_bit(d)));
         check("par_rand_rdy",  ready_b, 1);
         clear_b();
      end

      // Framing error
      send_rx(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
      check("frm_ready", ready_a, 1);
      check("frm_data",  dout_a, 8'h3C);
      check("frm_err",   ferr_a, 1);
      clear_a();
      check("frm_clr", ferr_a, 0);

      // Overrun
      send_rx(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      send_rx(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
      check("ovr_data",  dout_a, 8'h11);
      check("ovr_flag",  ovr_a, 1);
      check("ovr_ready", ready_a, 1);
      clear_a();
      check("ovr_clr", {ready_a, perr_a, ferr_a, ovr_a}, 0);

      // False start
      rx_a = 1'b0;
      cycles(20);
      rx_a = 1'b1;
      cycles(300);
      check("glitch_ready", ready_a, 0);
      send_rx(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
      check("glitch_next_data",  dout_a, 8'h5A);
      check("glitch_next_flags", {ready_a, perr_a, ferr_a, ovr_a}, 4'b1000);
      clear_a();

      // Reset mid-transmit
      loop_a    = 1'b1;
      data_in_a = 8'hFF;
      wr_en_a   = 1'b1;
      cycles(1);
      wr_en_a   = 1'b0;
      cycles(199);
      rst = 1'b1;
      cycles(1);
      check("rstmid_tx",   tx_a, 1);
      check("rstmid_busy", busy_a, 0);
      rst = 1'b0;
      cycles(1000);
      check("rstmid_ready", ready_a, 0);
      loop_a = 1'b0;

      // wr_en during busy is ignored; decode the line at mid-bit
      data_in_a = 8'h81;
      wr_en_a   = 1'b1;
      cycles(1);
      wr_en_a   = 1'b0;
      fr    = '0;
      extra = 0;
      for (int c = 0; c < 1400; c++) begin
         if (c == 100 || c == 300) begin
            data_in_a = 8'h00;
            wr_en_a   = 1'b1;
         end else begin
            wr_en_a   = 1'b0;
         end
         if ((c % BIT) == BIT / 2 && (c / BIT) < 10) fr[c / BIT] = tx_a;
         if (c >= 10 * BIT && (tx_a !== 1'b1 || busy_a !== 1'b0)) extra++;
         cycles(1);
      end
      check("busyw_start", fr[0], 0);
      check("busyw_data",  fr[8:1], 8'h81);
      check("busyw_stop",  fr[9], 1);
      check("busyw_extra", extra, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_cfg_core.md
# uart_cfg_core

Parametrised UART transceiver that succeeds the fixed 8N1 `uart_top`. It adds configurable data width, parity and stop bits, and a 16x-oversampled receiver with false-start rejection. Error reporting covers parity, framing and overrun, and an internal loopback mode is provided. The block sits between the register/host side (parallel byte handshake) and the board-level `tx`/`rx` pins.

## Interface
- `DATA_W`, 8, data bits per frame; legal values are 5–9.
- `PARITY`, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, stop bits per frame; legal values are 1 or 2.
- `OVS`, 16, receiver oversample ticks per bit; must be even and ≥ 8.
- `BAUD_DIV`, 27, `clk` cycles per oversample tick; must be ≥ 2. Bit period is `OVS*BAUD_DIV` cycles.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  DATA_W  transmit word, sampled when `wr_en` is accepted.
- `wr_en`  in  1  transmit request; accepted only when `busy`=0.
- `busy`  out  1  transmitter active.
- `tx`  out  1  serial output; idles high.
- `rx`  in  1  serial input; asynchronous.
- `loopback`  in  1  when 1, the receiver takes internal `tx` instead of `rx`.
- `data_out`  out  DATA_W  last received word.
- `ready`  out  1  `data_out` valid; sticky.
- `ready_clr`  in  1  clears `ready`, `parity_err`, `frame_err` and `overrun`.
- `parity_err`  out  1  parity mismatch on the word in `data_out`.
- `frame_err`  out  1  a stop bit was sampled low on the word in `data_out`.
- `overrun`  out  1  a frame completed while `ready`=1; that frame was dropped.

## Operation
- **Reset values:**
  - `tx`=1.
  - `busy`, `ready`, `parity_err`, `frame_err`, `overrun` all 0.
  - `data_out`=0.
  - Both FSMs in IDLE.
  - `rst` asserted mid-frame aborts immediately; there is no partial delivery.
- **TX FSM:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - Data is sent LSB first.
  - The parity bit is the XOR of the data bits, inverted for odd parity.
  - STOP lasts `STOP_BITS` bit periods.
  - The bit-period counter restarts on acceptance, so frame length is exact.
  - `wr_en` while `busy`=1 is ignored; there is no queueing.
- **RX input path:** `rx` passes through a 2-flop synchroniser. The `loopback` mux sits after the synchroniser (the `tx` path is not synchronised).
- **RX FSM:** IDLE → START → DATA → [PARITY] → STOP → IDLE. It advances on oversample ticks.
  - **IDLE:** on detecting a low level, reset the tick counter.
  - **START:** sample at `OVS/2` ticks. If the sample is high, treat it as a false start and return to IDLE with no flags set.
  - **DATA/PARITY/STOP:** sample every `OVS` ticks, i.e. at mid-bit.
  - A low sample on any stop bit sets the frame error for this frame.
  - After sampling the last stop bit, return to IDLE.
- **Delivery:** on frame completion, `data_out`, `parity_err` and `frame_err` load together and `ready` is set.
- **Overrun:** if `ready` is already 1 at completion, set `overrun`. In that case `data_out` and the error flags keep the old frame's values.
- **Simultaneous events:**
  - If `ready_clr` and frame completion fall in the same cycle, completion wins: `ready`=1, flags reflect the new frame, and `overrun` is 0.
  - If `wr_en` arrives in the same cycle that `busy` falls, it is not accepted.

## Timing
- If `wr_en` is accepted at edge N, `busy`=1 and `tx`=0 from edge N+1.
- TX frame length is `(1+DATA_W+(PARITY!=0)+STOP_BITS)*OVS*BAUD_DIV` cycles. `busy` falls on the cycle after the last stop period ends.
- `ready` rises one cycle after the mid-point sample of the last stop bit.
  - In loopback, `ready` therefore rises roughly half a bit before `busy` falls.
- `ready_clr` takes effect on the next edge.
- The oversample tick is free-running. The RX start sampling phase therefore has at most 1 tick (`BAUD_DIV` cycles) of uncertainty.

## Structure
- The `uart_pkg` package holds:
  - the parity enum (NONE/ODD/EVEN);
  - the TX/RX state enums;
  - a function `frame_bits(DATA_W, PARITY, STOP_BITS)`;
  - a function for the parity of a word.
- `uart_baud_gen` is a sub-module: a mod-`BAUD_DIV` counter emitting a one-cycle oversample tick.
- TX and RX are written as two always-blocks inside `uart_cfg_core`.

## Test plan
Use `BAUD_DIV`=4 and `OVS`=16, giving a 64-cycle bit.
- **Loopback 8N1:** with `loopback`=1, send 0x25, then 0x77 with `ready_clr` between them → `data_out`=0x25, then 0x77, with no error flags. `busy` is high for exactly 640 cycles per frame.
- **Even parity, bad parity bit:** with `PARITY`=2, drive `rx` with 0xA5 and a parity bit of 1 → `ready`=1, `data_out`=0xA5, `parity_err`=1.
- **Framing error:** with 8N1, drive `rx` with 0x3C and a low stop bit → `frame_err`=1 and `data_out`=0x3C.
- **Overrun:** receive 0x11 then 0x22 with no `ready_clr` → `data_out`=0x11 and `overrun`=1. `ready_clr` then clears all flags.
- **False start:** drive a 20-cycle low glitch on `rx` → `ready` stays 0. A following valid 0x5A is received correctly.
- **Reset and busy handling:**
  - Assert `rst` at cycle 200 of a 0xFF transmit → `tx`=1 and `busy`=0 on the next edge, and `ready` never rises.
  - `wr_en` pulsed during `busy` → ignored; only one frame appears on `tx`.
